muldiv_ctrl: RTL
================

# muldiv_ctrl

Multi-cycle multiply/divide controller for the EX stage. It decodes the R-type HI/LO instructions (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO) from opcode/funct, the same fields ALU decoding uses, and sequences an iterative radix-2 datapath over 32 steps. It owns the HI/LO registers and raises a stall to the pipeline whenever a HI/LO instruction arrives while an operation is in flight. ALU ops proceed in parallel and are never stalled by this block.

## Interface
- WIDTH, 32: operand/HI/LO width; iteration count equals WIDTH.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  EX-stage instruction is valid (not bubble)
- opcode  in  6  instruction bits [31:26]
- funct  in  6  instruction bits [5:0]
- rs_val  in  WIDTH  forwarded rs operand (dividend / multiplicand / MTxx source)
- rt_val  in  WIDTH  forwarded rt operand (divisor / multiplier)
- stall  out  1  hold EX and earlier stages this cycle
- busy  out  1  operation in flight
- result  out  WIDTH  HI or LO value for MFHI/MFLO, 0 otherwise
- hi, lo  out  WIDTH  architectural HI/LO (debug/visibility)

## Operation
- Decoded op = opcode==RTYPE && funct in {MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13}; hilo_op = valid && decoded op.
- stall = hilo_op && busy (combinational). Stalled instruction is re-presented; it is accepted in the first cycle busy==0.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE: on accepted MULT/MULTU -> MUL; DIV/DIVU -> DIV. Capture operand magnitudes (signed ops: absolute value, 2's complement; unsigned: as-is), record sign_q = rs[31]^rt[31] and sign_r = rs[31] (both 0 for unsigned), count = 0.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product accumulator; count++; at count==WIDTH-1 -> FIX.
- DIV: restoring divide, one quotient bit per cycle; remainder WIDTH+1 bits; count++; at count==WIDTH-1 -> FIX.
- FIX: apply signs (MUL: negate 64-bit product if sign_q; DIV: negate quotient if sign_q, remainder if sign_r); write HI/LO (MUL: HI=upper, LO=lower; DIV: HI=remainder, LO=quotient); -> IDLE.
- Divide by zero (rt_val==0 at accept): full latency still spent; FIX forces LO=all ones, HI=rs_val as captured (unsigned) / original rs_val (signed).
- 0x80000000 / -1 signed: LO=0x80000000, HI=0 (natural wrap).
- MTHI/MTLO accepted in IDLE: write HI/LO at that edge; no state change.
- MFHI/MFLO accepted: result = hi/lo combinationally that cycle.
- Non-HI/LO instructions: ignored, never stalled, regardless of busy.
- Reset: state IDLE, count 0, hi=lo=0, busy=0, stall=0, result=0. Reset mid-operation aborts; HI/LO cleared, not partially written.

## Timing
- busy = (state != IDLE), registered.
- MULT/DIV accepted at edge E0: busy high cycles 1..WIDTH+1 (33 cycles at WIDTH=32); HI/LO valid after edge E0+33; first non-stalled MFxx at cycle 33 after accept.
- Back-to-back MULT after MULT: second stalls until busy low, then accepted same cycle busy falls.
- MTxx/MFxx while idle: zero latency, no stall.
- rst wins over any simultaneous accept.

## Structure
- Add funct codes MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO, MTLO to Opcode.vh; FSM state encodings as a new shared header MulDiv.vh.
- One sub-module: muldiv_iter (single-step shift-add / restoring-subtract datapath, combinational, selected by a mul/div bit); FSM, sign handling, HI/LO and stall logic stay in muldiv_ctrl.

## Test plan
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=100; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT 5*6 then MFLO presented 4 cycles later -> stall high until busy falls, then result=30, stall 0; ADDU presented during busy -> stall 0.
- MTHI 0x1234 then MFHI idle -> no stall, result=0x1234 next cycle.
- MULT in flight, rst at iteration 10 -> next cycle busy=0, hi=lo=0; MFLO returns 0 with no stall.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared decode constants and FSM state encoding for the HI/LO multiply/divide unit.
// Funct codes are the R-type HI/LO group; everything else is left to the ALU.
package muldiv_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  function automatic logic is_hilo_funct(input logic [5:0] f);
    return f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                     FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step of the iterative datapath: shift-add multiply or restoring divide.
// The accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
  assign shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
  assign ge      = shifted >= {1'b0, opnd};
  // When ge holds the true difference is below opnd, so the low WIDTH bits are exact.
  assign diff    = shifted[WIDTH-1:0] - opnd;

  assign acc_out = is_div ? {(ge ? diff : shifted[WIDTH-1:0]), acc_in[WIDTH-2:0], ge}
                          : {sum, acc_in[WIDTH-1:1]};

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: decodes HI/LO instructions, sequences 32 datapath
// steps plus a sign-fixup cycle, owns HI/LO and stalls HI/LO instructions while busy.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t             state, next_state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   opnd, rs_orig;
  logic               sign_q, sign_r, div_zero, div_mode;
  logic               hilo_op, accept, start_mul, start_div, is_signed;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  assign hilo_op   = valid && (opcode == OP_RTYPE) && is_hilo_funct(funct);
  assign busy      = (state != ST_IDLE);
  assign stall     = hilo_op && busy;
  assign accept    = hilo_op && !busy;
  assign start_mul = accept && (funct == FN_MULT || funct == FN_MULTU);
  assign start_div = accept && (funct == FN_DIV  || funct == FN_DIVU);
  assign is_signed = (funct == FN_MULT) || (funct == FN_DIV);

  assign rs_mag = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  assign result = (accept && funct == FN_MFHI) ? hi :
                  (accept && funct == FN_MFLO) ? lo : '0;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div  (state == ST_DIV),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_mul)      next_state = ST_MUL;
        else if (start_div) next_state = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (count == CW'(WIDTH - 1)) next_state = ST_FIX;
      end
      ST_FIX:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      rs_orig  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      div_mode <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_mul || start_div) begin
            count    <= '0;
            // Multiply: rs is the multiplicand, rt shifts out from the low half.
            // Divide: rs shifts out as the dividend, rt is the divisor.
            opnd     <= start_mul ? rs_mag : rt_mag;
            acc      <= {{WIDTH{1'b0}}, (start_mul ? rt_mag : rs_mag)};
            rs_orig  <= rs_val;
            sign_q   <= is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            sign_r   <= is_signed && rs_val[WIDTH-1];
            div_zero <= (rt_val == '0);
            div_mode <= start_div;
          end else if (accept && funct == FN_MTHI) begin
            hi <= rs_val;
          end else if (accept && funct == FN_MTLO) begin
            lo <= rs_val;
          end
        end
        ST_MUL, ST_DIV: begin
          acc   <= acc_next;
          count <= count + 1'b1;
        end
        ST_FIX: begin
          if (!div_mode) begin
            {hi, lo} <= sign_q ? -acc : acc;
          end else if (div_zero) begin
            lo <= '1;
            hi <= rs_orig;
          end else begin
            lo <= sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi <= sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
